// File: rtl/regfile_wb_scheduler_pkg.sv
// Shared register-file constants, opcode encodings and write-back source type
// used by the hazard scoreboard and its write-back arbiter.
package regfile_wb_scheduler_pkg;

  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned NUM_REGS   = 32;

  localparam logic [6:0] OPC_R = 7'b0110011;
  localparam logic [6:0] OPC_I = 7'b0010011;
  localparam logic [6:0] OPC_S = 7'b0100011;
  localparam logic [6:0] OPC_B = 7'b1100011;
  localparam logic [6:0] OPC_L = 7'b0000011;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;

  typedef enum logic {
    WB_ALU = 1'b0,
    WB_LSU = 1'b1
  } wb_src_e;

  // x0 is hardwired to zero, so writes to it never create a pending result.
  function automatic logic writes_reg(input logic we, input reg_addr_t rd);
    return we & (rd != '0);
  endfunction

endpackage

// File: rtl/regfile_wb_scheduler_wb_rr_arbiter.sv
// Two-requester round-robin arbiter for the register-bank write port.
// rr_last remembers the most recent winner; on a tie the other unit wins.
module wb_rr_arbiter
  import regfile_wb_scheduler_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic alu_req,
  input  logic lsu_req,
  output logic alu_gnt,
  output logic lsu_gnt
);

  wb_src_e rr_last_q;

  always_comb begin
    alu_gnt = alu_req & (~lsu_req | (rr_last_q == WB_LSU));
    lsu_gnt = lsu_req & (~alu_req | (rr_last_q == WB_ALU));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_last_q <= WB_LSU;
    end else if (alu_gnt) begin
      rr_last_q <= WB_ALU;
    end else if (lsu_gnt) begin
      rr_last_q <= WB_LSU;
    end
  end

endmodule

// File: rtl/regfile_wb_scheduler.sv
// Hazard scoreboard and write-back scheduler: gates operand reads on RAW/WAW
// hazards and feeds the single register-bank write port from ALU and LSU.
module regfile_wb_scheduler
  import regfile_wb_scheduler_pkg::*;
#(
  parameter int unsigned MAX_PENDING = 4,
  parameter int unsigned XLEN        = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            issue_valid,
  input  logic [4:0]      issue_rs1,
  input  logic [4:0]      issue_rs2,
  input  logic [4:0]      issue_rd,
  input  logic            issue_rd_we,
  output logic            issue_ready,
  output logic            rd_en,
  output logic            stall,
  input  logic            alu_wb_valid,
  input  logic [4:0]      alu_wb_rd,
  input  logic [XLEN-1:0] alu_wb_data,
  output logic            alu_wb_ready,
  input  logic            lsu_wb_valid,
  input  logic [4:0]      lsu_wb_rd,
  input  logic [XLEN-1:0] lsu_wb_data,
  output logic            lsu_wb_ready,
  output logic            rf_we,
  output logic [4:0]      rf_waddr,
  output logic [XLEN-1:0] rf_wdata,
  output logic [3:0]      pending_cnt
);

  localparam logic [3:0] MaxPend = 4'(MAX_PENDING);

  logic [NUM_REGS-1:0] busy_q, busy_d;
  logic [3:0]          pending_q, pending_d;
  logic                rf_we_q;
  reg_addr_t           rf_waddr_q;
  logic [XLEN-1:0]     rf_wdata_q;

  logic      issue_fire, sb_set, sb_clr;
  logic      alu_gnt, lsu_gnt, wb_gnt;
  reg_addr_t wb_rd;
  logic [XLEN-1:0] wb_data;

  // Issue decision looks only at registered scoreboard state.
  always_comb begin
    issue_ready = ~busy_q[issue_rs1] & ~busy_q[issue_rs2] &
                  ~(issue_rd_we & busy_q[issue_rd]) & (pending_q < MaxPend);
    issue_fire  = issue_valid & issue_ready;
    rd_en       = issue_fire;
    stall       = issue_valid & ~issue_ready;
    sb_set      = issue_fire & writes_reg(issue_rd_we, issue_rd);
    sb_clr      = rf_we_q;
  end

  always_comb begin
    busy_d = busy_q;
    if (sb_clr) busy_d[rf_waddr_q] = 1'b0;
    if (sb_set) busy_d[issue_rd] = 1'b1;
    busy_d[0] = 1'b0;
  end

  // A simultaneous set and clear leave the count unchanged; a clear at zero saturates.
  always_comb begin
    pending_d = pending_q;
    case ({sb_set, sb_clr})
      2'b10:   pending_d = pending_q + 4'd1;
      2'b01:   pending_d = (pending_q != '0) ? pending_q - 4'd1 : pending_q;
      2'b11:   pending_d = (pending_q != '0) ? pending_q : 4'd1;
      default: pending_d = pending_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy_q    <= '0;
      pending_q <= '0;
    end else begin
      busy_q    <= busy_d;
      pending_q <= pending_d;
    end
  end

  wb_rr_arbiter u_arb (
    .clk     (clk),
    .rst     (rst),
    .alu_req (alu_wb_valid),
    .lsu_req (lsu_wb_valid),
    .alu_gnt (alu_gnt),
    .lsu_gnt (lsu_gnt)
  );

  always_comb begin
    alu_wb_ready = alu_gnt;
    lsu_wb_ready = lsu_gnt;
    wb_gnt       = alu_gnt | lsu_gnt;
    wb_rd        = alu_gnt ? alu_wb_rd : lsu_wb_rd;
    wb_data      = alu_gnt ? alu_wb_data : lsu_wb_data;
  end

  // Results granted to x0 are consumed but never reach the bank.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rf_we_q    <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
    end else begin
      rf_we_q <= wb_gnt & (wb_rd != '0);
      if (wb_gnt) begin
        rf_waddr_q <= wb_rd;
        rf_wdata_q <= wb_data;
      end
    end
  end

  assign rf_we       = rf_we_q;
  assign rf_waddr    = rf_waddr_q;
  assign rf_wdata    = rf_wdata_q;
  assign pending_cnt = pending_q;

  pending_underflow_a: assert property (
    @(posedge clk) disable iff (!rst) sb_clr |-> (pending_q != '0));

endmodule

// File: tb/tb_regfile_wb_scheduler.sv
// Self-checking bench for regfile_wb_scheduler: directed scenarios plus a
// randomized run against a set/queue-based reference model.
module tb_regfile_wb_scheduler;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        issue_valid, issue_rd_we, issue_ready, rd_en, stall;
  logic [4:0]  issue_rs1, issue_rs2, issue_rd;
  logic        alu_wb_valid, alu_wb_ready, lsu_wb_valid, lsu_wb_ready;
  logic [4:0]  alu_wb_rd, lsu_wb_rd, rf_waddr;
  logic [31:0] alu_wb_data, lsu_wb_data, rf_wdata;
  logic        rf_we;
  logic [3:0]  pending_cnt;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  regfile_wb_scheduler #(.MAX_PENDING(4), .XLEN(32)) dut (
    .clk(clk), .rst(rst),
    .issue_valid(issue_valid), .issue_rs1(issue_rs1), .issue_rs2(issue_rs2),
    .issue_rd(issue_rd), .issue_rd_we(issue_rd_we), .issue_ready(issue_ready),
    .rd_en(rd_en), .stall(stall),
    .alu_wb_valid(alu_wb_valid), .alu_wb_rd(alu_wb_rd), .alu_wb_data(alu_wb_data),
    .alu_wb_ready(alu_wb_ready),
    .lsu_wb_valid(lsu_wb_valid), .lsu_wb_rd(lsu_wb_rd), .lsu_wb_data(lsu_wb_data),
    .lsu_wb_ready(lsu_wb_ready),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .pending_cnt(pending_cnt)
  );

  task automatic set_issue(input logic v, input logic [4:0] r1, input logic [4:0] r2,
                           input logic [4:0] rd, input logic we);
    issue_valid = v; issue_rs1 = r1; issue_rs2 = r2; issue_rd = rd; issue_rd_we = we;
  endtask

  task automatic set_alu(input logic v, input logic [4:0] rd, input logic [31:0] d);
    alu_wb_valid = v; alu_wb_rd = rd; alu_wb_data = d;
  endtask

  task automatic set_lsu(input logic v, input logic [4:0] rd, input logic [31:0] d);
    lsu_wb_valid = v; lsu_wb_rd = rd; lsu_wb_data = d;
  endtask

  task automatic idle();
    set_issue(1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
    set_alu(1'b0, 5'd0, 32'd0);
    set_lsu(1'b0, 5'd0, 32'd0);
  endtask

  // Inputs change just after the rising edge; outputs are sampled on the falling edge.
  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  task automatic apply_reset();
    idle();
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
  endtask

  task automatic test_reset();
    idle();
    rst = 1'b0;
    #2;
    checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL rst_we: got %0b want 0", rf_we); end
    checks++; if (rf_waddr !== 5'd0) begin errors++; $display("FAIL rst_waddr: got %0d want 0", rf_waddr); end
    checks++; if (rf_wdata !== 32'd0) begin errors++; $display("FAIL rst_wdata: got %0h want 0", rf_wdata); end
    checks++; if (pending_cnt !== 4'd0) begin errors++; $display("FAIL rst_cnt: got %0d want 0", pending_cnt); end
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    set_issue(1'b1, 5'd0, 5'd0, 5'd9, 1'b1);
    settle();
    checks++; if (issue_ready !== 1'b1) begin errors++; $display("FAIL rst_issue: got %0b want 1", issue_ready); end
    cyc();
    set_issue(1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
    set_alu(1'b1, 5'd9, 32'hA5A5_0009);
    settle();
    checks++; if (alu_wb_ready !== 1'b1) begin errors++; $display("FAIL rst_grant: got %0b want 1", alu_wb_ready); end
    cyc();
    set_alu(1'b0, 5'd0, 32'd0);
    settle();
    checks++; if (rf_we !== 1'b1) begin errors++; $display("FAIL rst_pre_we: got %0b want 1", rf_we); end
    #1 rst = 1'b0;
    #1;
    checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL rst_mid_we: got %0b want 0", rf_we); end
    checks++; if (pending_cnt !== 4'd0) begin errors++; $display("FAIL rst_mid_cnt: got %0d want 0", pending_cnt); end
    cyc();
    rst = 1'b1;
    set_issue(1'b1, 5'd9, 5'd9, 5'd9, 1'b1);
    settle();
    checks++; if (issue_ready !== 1'b1) begin errors++; $display("FAIL rst_busy9: got %0b want 1", issue_ready); end
    set_issue(1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
    set_alu(1'b1, 5'd0, 32'd1);
    set_lsu(1'b1, 5'd0, 32'd2);
    #1;
    checks++; if (alu_wb_ready !== 1'b1) begin errors++; $display("FAIL rst_tie_alu: got %0b want 1", alu_wb_ready); end
    checks++; if (lsu_wb_ready !== 1'b0) begin errors++; $display("FAIL rst_tie_lsu: got %0b want 0", lsu_wb_ready); end
    cyc();
    idle();
  endtask

  task automatic test_raw();
    apply_reset();
    set_issue(1'b1, 5'd0, 5'd0, 5'd5, 1'b1);
    settle();
    checks++; if (issue_ready !== 1'b1) begin errors++; $display("FAIL raw_first: got %0b want 1", issue_ready); end
    cyc();
    set_issue(1'b1, 5'd5, 5'd0, 5'd6, 1'b1);
    settle();
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL raw_stall: got %0b want 1", stall); end
    checks++; if (rd_en !== 1'b0) begin errors++; $display("FAIL raw_rden: got %0b want 0", rd_en); end
    cyc();
    set_alu(1'b1, 5'd5, 32'h0000_1234);
    settle();
    checks++; if (alu_wb_ready !== 1'b1) begin errors++; $display("FAIL raw_grant: got %0b want 1", alu_wb_ready); end
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL raw_stall_n: got %0b want 1", stall); end
    cyc();
    set_alu(1'b0, 5'd0, 32'd0);
    settle();
    checks++; if (rf_we !== 1'b1) begin errors++; $display("FAIL raw_we: got %0b want 1", rf_we); end
    checks++; if (rf_waddr !== 5'd5) begin errors++; $display("FAIL raw_waddr: got %0d want 5", rf_waddr); end
    checks++; if (rf_wdata !== 32'h1234) begin errors++; $display("FAIL raw_wdata: got %0h want 1234", rf_wdata); end
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL raw_stall_n1: got %0b want 1", stall); end
    cyc();
    settle();
    checks++; if (issue_ready !== 1'b1) begin errors++; $display("FAIL raw_n2: got %0b want 1", issue_ready); end
    checks++; if (rd_en !== 1'b1) begin errors++; $display("FAIL raw_n2_rden: got %0b want 1", rd_en); end
    cyc();
    idle();
  endtask

  task automatic test_tie();
    apply_reset();
    set_issue(1'b1, 5'd0, 5'd0, 5'd3, 1'b1);
    cyc();
    set_issue(1'b1, 5'd0, 5'd0, 5'd4, 1'b1);
    cyc();
    set_issue(1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
    set_alu(1'b1, 5'd3, 32'hAAAA_0003);
    set_lsu(1'b1, 5'd4, 32'hBBBB_0004);
    settle();
    checks++; if (alu_wb_ready !== 1'b1) begin errors++; $display("FAIL tie_alu: got %0b want 1", alu_wb_ready); end
    checks++; if (lsu_wb_ready !== 1'b0) begin errors++; $display("FAIL tie_lsu: got %0b want 0", lsu_wb_ready); end
    checks++; if (pending_cnt !== 4'd2) begin errors++; $display("FAIL tie_cnt: got %0d want 2", pending_cnt); end
    cyc();
    set_alu(1'b0, 5'd0, 32'd0);
    settle();
    checks++; if (lsu_wb_ready !== 1'b1) begin errors++; $display("FAIL tie_lsu2: got %0b want 1", lsu_wb_ready); end
    checks++; if (rf_waddr !== 5'd3) begin errors++; $display("FAIL tie_waddr3: got %0d want 3", rf_waddr); end
    checks++; if (rf_wdata !== 32'hAAAA_0003) begin errors++; $display("FAIL tie_wdata3: got %0h", rf_wdata); end
    cyc();
    set_lsu(1'b0, 5'd0, 32'd0);
    settle();
    checks++; if (rf_we !== 1'b1) begin errors++; $display("FAIL tie_we4: got %0b want 1", rf_we); end
    checks++; if (rf_waddr !== 5'd4) begin errors++; $display("FAIL tie_waddr4: got %0d want 4", rf_waddr); end
    checks++; if (rf_wdata !== 32'hBBBB_0004) begin errors++; $display("FAIL tie_wdata4: got %0h", rf_wdata); end
    cyc();
    settle();
    checks++; if (pending_cnt !== 4'd0) begin errors++; $display("FAIL tie_cnt0: got %0d want 0", pending_cnt); end
    checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL tie_idle_we: got %0b want 0", rf_we); end
    idle();
  endtask

  task automatic test_full();
    apply_reset();
    for (int r = 1; r <= 4; r++) begin
      set_issue(1'b1, 5'd0, 5'd0, 5'(r), 1'b1);
      settle();
      checks++; if (issue_ready !== 1'b1) begin errors++; $display("FAIL full_issue%0d: got %0b want 1", r, issue_ready); end
      cyc();
    end
    set_issue(1'b1, 5'd0, 5'd0, 5'd5, 1'b1);
    set_alu(1'b1, 5'd1, 32'hCAFE_0001);
    settle();
    checks++; if (pending_cnt !== 4'd4) begin errors++; $display("FAIL full_cnt4: got %0d want 4", pending_cnt); end
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL full_stall: got %0b want 1", stall); end
    cyc();
    set_alu(1'b0, 5'd0, 32'd0);
    settle();
    checks++; if (rf_we !== 1'b1 || rf_waddr !== 5'd1) begin
      errors++; $display("FAIL full_commit: got we=%0b addr=%0d want 1/1", rf_we, rf_waddr); end
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL full_stall_n1: got %0b want 1", stall); end
    cyc();
    settle();
    checks++; if (pending_cnt !== 4'd3) begin errors++; $display("FAIL full_cnt3: got %0d want 3", pending_cnt); end
    checks++; if (issue_ready !== 1'b1) begin errors++; $display("FAIL full_resume: got %0b want 1", issue_ready); end
    cyc();
    idle();
    settle();
    checks++; if (pending_cnt !== 4'd4) begin errors++; $display("FAIL full_cnt4b: got %0d want 4", pending_cnt); end
  endtask

  task automatic test_x0();
    apply_reset();
    set_issue(1'b1, 5'd0, 5'd0, 5'd0, 1'b1);
    settle();
    checks++; if (issue_ready !== 1'b1) begin errors++; $display("FAIL x0_issue: got %0b want 1", issue_ready); end
    cyc();
    set_issue(1'b1, 5'd0, 5'd0, 5'd0, 1'b1);
    set_lsu(1'b1, 5'd0, 32'hDEAD_BEEF);
    settle();
    checks++; if (pending_cnt !== 4'd0) begin errors++; $display("FAIL x0_cnt: got %0d want 0", pending_cnt); end
    checks++; if (issue_ready !== 1'b1) begin errors++; $display("FAIL x0_notbusy: got %0b want 1", issue_ready); end
    checks++; if (lsu_wb_ready !== 1'b1) begin errors++; $display("FAIL x0_grant: got %0b want 1", lsu_wb_ready); end
    cyc();
    idle();
    settle();
    checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL x0_we: got %0b want 0", rf_we); end
    checks++; if (pending_cnt !== 4'd0) begin errors++; $display("FAIL x0_cnt2: got %0d want 0", pending_cnt); end
  endtask

  task automatic test_concurrent();
    apply_reset();
    set_issue(1'b1, 5'd0, 5'd0, 5'd6, 1'b1);
    cyc();
    set_issue(1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
    set_alu(1'b1, 5'd6, 32'h0000_0066);
    cyc();
    set_alu(1'b0, 5'd0, 32'd0);
    set_issue(1'b1, 5'd0, 5'd0, 5'd7, 1'b1);
    settle();
    checks++; if (rf_we !== 1'b1 || rf_waddr !== 5'd6) begin
      errors++; $display("FAIL conc_commit: got we=%0b addr=%0d want 1/6", rf_we, rf_waddr); end
    checks++; if (issue_ready !== 1'b1) begin errors++; $display("FAIL conc_issue: got %0b want 1", issue_ready); end
    checks++; if (pending_cnt !== 4'd1) begin errors++; $display("FAIL conc_cnt_pre: got %0d want 1", pending_cnt); end
    cyc();
    set_issue(1'b1, 5'd6, 5'd0, 5'd0, 1'b0);
    settle();
    checks++; if (pending_cnt !== 4'd1) begin errors++; $display("FAIL conc_cnt: got %0d want 1", pending_cnt); end
    checks++; if (issue_ready !== 1'b1) begin errors++; $display("FAIL conc_busy6: got %0b want 1", issue_ready); end
    set_issue(1'b1, 5'd0, 5'd7, 5'd0, 1'b0);
    #1;
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL conc_busy7: got %0b want 1", stall); end
    cyc();
    idle();
  endtask

  task automatic test_random();
    bit          mb [32];
    int          mcnt;
    bit          last_lsu;
    bit          pw;
    logic [4:0]  pa;
    logic [31:0] pd;
    logic [4:0]  alu_q[$];
    logic [4:0]  lsu_q[$];
    bit          ah, lh, e_ready, e_ag, e_lg;
    logic [4:0]  ard, lrd;
    logic [31:0] adat, ldat;
    apply_reset();
    for (int i = 0; i < 32; i++) mb[i] = 1'b0;
    mcnt = 0; last_lsu = 1'b1; pw = 1'b0; pa = '0; pd = '0;
    ah = 1'b0; lh = 1'b0; ard = '0; lrd = '0; adat = '0; ldat = '0;
    for (int c = 0; c < 600; c++) begin
      set_issue(1'($urandom_range(1)), 5'($urandom_range(7)), 5'($urandom_range(7)),
                5'($urandom_range(7)), 1'($urandom_range(1)));
      if (!ah) begin
        if (alu_q.size() > 0 && $urandom_range(2) != 0) begin
          ah = 1'b1; ard = alu_q.pop_front(); adat = $urandom;
        end else if ($urandom_range(15) == 0) begin
          ah = 1'b1; ard = 5'd0; adat = $urandom;
        end
      end
      if (!lh) begin
        if (lsu_q.size() > 0 && $urandom_range(2) != 0) begin
          lh = 1'b1; lrd = lsu_q.pop_front(); ldat = $urandom;
        end else if ($urandom_range(15) == 0) begin
          lh = 1'b1; lrd = 5'd0; ldat = $urandom;
        end
      end
      set_alu(ah, ard, adat);
      set_lsu(lh, lrd, ldat);
      settle();
      e_ready = !mb[issue_rs1] && !mb[issue_rs2] && !(issue_rd_we && mb[issue_rd]) && (mcnt < 4);
      e_ag = ah && (!lh || last_lsu);
      e_lg = lh && (!ah || !last_lsu);
      checks++; if (issue_ready !== e_ready) begin
        errors++; $display("FAIL rnd_ready c=%0d: got %0b want %0b", c, issue_ready, e_ready); end
      checks++; if (stall !== (issue_valid && !e_ready)) begin
        errors++; $display("FAIL rnd_stall c=%0d: got %0b want %0b", c, stall, issue_valid && !e_ready); end
      checks++; if (alu_wb_ready !== e_ag || lsu_wb_ready !== e_lg) begin
        errors++; $display("FAIL rnd_grant c=%0d: got %0b%0b want %0b%0b", c,
                           alu_wb_ready, lsu_wb_ready, e_ag, e_lg); end
      checks++; if (rf_we !== pw) begin errors++; $display("FAIL rnd_we c=%0d: got %0b want %0b", c, rf_we, pw); end
      if (pw) begin
        checks++; if (rf_waddr !== pa || rf_wdata !== pd) begin
          errors++; $display("FAIL rnd_wport c=%0d: got %0d/%0h want %0d/%0h", c,
                             rf_waddr, rf_wdata, pa, pd); end
      end
      checks++; if (pending_cnt !== 4'(mcnt)) begin
        errors++; $display("FAIL rnd_cnt c=%0d: got %0d want %0d", c, pending_cnt, mcnt); end
      cyc();
      if (pw) begin
        mb[pa] = 1'b0;
        if (mcnt > 0) mcnt--;
      end
      if (issue_valid && e_ready && issue_rd_we && issue_rd != 5'd0) begin
        mb[issue_rd] = 1'b1;
        mcnt++;
        if ($urandom_range(1) == 1) alu_q.push_back(issue_rd);
        else lsu_q.push_back(issue_rd);
      end
      pw = 1'b0;
      if (e_ag) begin
        pw = (ard != 5'd0); pa = ard; pd = adat; ah = 1'b0; last_lsu = 1'b0;
      end else if (e_lg) begin
        pw = (lrd != 5'd0); pa = lrd; pd = ldat; lh = 1'b0; last_lsu = 1'b1;
      end
    end
    idle();
  endtask

  initial begin
    idle();
    test_reset();
    test_raw();
    test_tie();
    test_full();
    test_x0();
    test_concurrent();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

endmodule
